// File: rtl/ips2l_pcie_dma_pkg.sv
// Shared TLP constants and FSM encoding for the DMA example-design completer path.
package ips2l_pcie_dma_pkg;

  localparam logic [2:0] FMT_CPLD      = 3'b010;
  localparam logic [2:0] FMT_CPL       = 3'b000;
  localparam logic [4:0] TYPE_CPL      = 5'b01010;
  localparam logic [2:0] CPL_STATUS_SC = 3'b000;
  localparam logic [2:0] CPL_STATUS_UR = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2
  } cpld_state_e;

  // Contiguous keep mask for n valid DWs; n == 0 means a full beat.
  function automatic logic [3:0] keep_mask(input logic [1:0] n);
    case (n)
      2'd1:    return 4'b0001;
      2'd2:    return 4'b0011;
      2'd3:    return 4'b0111;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ips2l_pcie_dma_dw_align.sv
// DW realigner: merges the previous and current BAR RAM words into one packed 4-DW beat.
module ips2l_pcie_dma_dw_align
  import ips2l_pcie_dma_pkg::*;
(
  input  logic         clk,
  input  logic         adv,
  input  logic [1:0]   shift,
  input  logic         last,
  input  logic [1:0]   tail_dw,
  input  logic [127:0] cur_word,
  output logic [127:0] data,
  output logic [3:0]   keep
);

  logic [95:0]  prev_hi;
  logic [223:0] window;
  logic [127:0] shifted;

  // NOTE: datapath-only register, no reset; beat 0 replaces every lane it could feed with header DWs.
  always_ff @(posedge clk) begin
    if (adv) prev_hi <= cur_word[127:32];
  end

  assign window = {cur_word, prev_hi};

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    shifted = window[127:0];
    case (shift)
      2'd1:    shifted = window[159:32];
      2'd2:    shifted = window[191:64];
      2'd3:    shifted = window[223:96];
      default: ;
    endcase
  end

  always_comb begin
    keep = last ? keep_mask(tail_dw) : 4'b1111;
    data = '0;
    for (int i = 0; i < 4; i++) begin
      if (keep[i]) data[32*i +: 32] = shifted[32*i +: 32];
    end
  end

endmodule

// File: rtl/ips2l_pcie_dma_tx_cpld_gen.sv
// Completer TX: turns accepted MRd requests into CplD (or header-only UR Cpl) TLPs on 128-bit AXIS.
// Optional completion counter is built only when IPS2L_DMA_TX_CPLD_CNT_EN is defined.
module ips2l_pcie_dma_tx_cpld_gen
  import ips2l_pcie_dma_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int MAX_CPL_DW = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           i_cfg_completer_id,
  input  logic [2:0]            i_mrd_tc,
  input  logic [2:0]            i_mrd_attr,
  input  logic [9:0]            i_mrd_length,
  input  logic [15:0]           i_mrd_id,
  input  logic [7:0]            i_mrd_tag,
  input  logic [63:0]           i_mrd_addr,
  input  logic                  i_cpld_req_vld,
  output logic                  o_cpld_req_rdy,
  output logic                  o_bar_rd_clk_en,
  output logic [ADDR_WIDTH-1:0] o_bar_rd_addr,
  input  logic [127:0]          i_bar_rd_data,
  output logic                  o_axis_slave_tvld,
  input  logic                  i_axis_slave_trdy,
  output logic [127:0]          o_axis_slave_tdata,
  output logic [3:0]            o_axis_slave_tkeep,
  output logic                  o_axis_slave_tlast,
  output logic [31:0]           o_cpld_cnt
);

  cpld_state_e state, state_nxt;

  logic [2:0]  r_tc;
  logic [1:0]  r_attr;
  logic [9:0]  r_length;
  logic [15:0] r_id;
  logic [7:0]  r_tag;
  logic [4:0]  r_addr_lo;
  logic [1:0]  r_offset;
  logic [1:0]  r_tail_dw;
  logic        r_is_ur;
  logic [8:0]  r_last_beat;
  logic [8:0]  beat_idx;

  logic [10:0]  req_len_dw;
  logic         req_is_ur;
  logic         accept, beat_done, last_beat, rd_en;
  logic [31:0]  hdr_dw0, hdr_dw1, hdr_dw2;
  logic [127:0] align_data;
  logic [3:0]   align_keep;
  logic         unused_bits;

  assign req_len_dw  = (i_mrd_length == 10'd0) ? 11'd1024 : {1'b0, i_mrd_length};
  assign req_is_ur   = (req_len_dw > 11'(MAX_CPL_DW));
  assign accept      = i_cpld_req_vld && o_cpld_req_rdy;
  assign last_beat   = (beat_idx == r_last_beat);
  assign beat_done   = o_axis_slave_tvld && i_axis_slave_trdy;
  assign unused_bits = ^{i_mrd_addr[63:ADDR_WIDTH+4], i_mrd_addr[1:0], i_mrd_attr[2]};

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (i_cpld_req_vld) state_nxt = req_is_ur ? ST_SEND : ST_FETCH;
      ST_FETCH: state_nxt = ST_SEND;
      ST_SEND:  if (i_axis_slave_trdy && last_beat) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // One RAM read per beat; the read for beat n+1 is issued as beat n completes.
  always_comb begin
    o_cpld_req_rdy    = 1'b0;
    o_axis_slave_tvld = 1'b0;
    rd_en             = 1'b0;
    case (state)
      ST_IDLE:  o_cpld_req_rdy = 1'b1;
      ST_FETCH: rd_en = 1'b1;
      ST_SEND: begin
        o_axis_slave_tvld = 1'b1;
        rd_en             = !r_is_ur && i_axis_slave_trdy && !last_beat;
      end
      default: ;
    endcase
  end

  assign o_bar_rd_clk_en = rd_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      o_bar_rd_addr <= '0;
      beat_idx      <= '0;
    end else if (accept) begin
      o_bar_rd_addr <= i_mrd_addr[ADDR_WIDTH+3:4];
      beat_idx      <= '0;
    end else begin
      if (rd_en)     o_bar_rd_addr <= o_bar_rd_addr + 1'b1;
      if (beat_done) beat_idx      <= beat_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      r_tc        <= i_mrd_tc;
      r_attr      <= i_mrd_attr[1:0];
      r_length    <= i_mrd_length;
      r_id        <= i_mrd_id;
      r_tag       <= i_mrd_tag;
      r_addr_lo   <= i_mrd_addr[6:2];
      r_offset    <= i_mrd_addr[3:2];
      r_tail_dw   <= i_mrd_length[1:0] + 2'd3;
      r_is_ur     <= req_is_ur;
      r_last_beat <= req_is_ur ? 9'd0 : 9'((req_len_dw + 11'd2) >> 2);
    end
  end

  // Byte count is 4*L in 12 bits, so a 1024-DW length (field 0) wraps to 0.
  assign hdr_dw0 = {r_is_ur ? FMT_CPL : FMT_CPLD, TYPE_CPL, 1'b0, r_tc, 4'b0000,
                    2'b00, r_attr, 2'b00, r_is_ur ? 10'd0 : r_length};
  assign hdr_dw1 = {i_cfg_completer_id, r_is_ur ? CPL_STATUS_UR : CPL_STATUS_SC, 1'b0,
                    r_length, 2'b00};
  assign hdr_dw2 = {r_id, r_tag, 1'b0, r_addr_lo, 2'b00};

  ips2l_pcie_dma_dw_align u_dw_align (
    .clk      (clk),
    .adv      (rd_en),
    .shift    (r_offset),
    .last     (last_beat),
    .tail_dw  (r_tail_dw),
    .cur_word (i_bar_rd_data),
    .data     (align_data),
    .keep     (align_keep)
  );

  always_comb begin
    o_axis_slave_tdata = '0;
    o_axis_slave_tkeep = '0;
    o_axis_slave_tlast = 1'b0;
    if (state == ST_SEND) begin
      o_axis_slave_tlast = last_beat;
      if (r_is_ur) begin
        o_axis_slave_tdata = {32'd0, hdr_dw2, hdr_dw1, hdr_dw0};
        o_axis_slave_tkeep = 4'b0111;
      end else begin
        o_axis_slave_tdata = align_data;
        o_axis_slave_tkeep = align_keep;
        if (beat_idx == '0) o_axis_slave_tdata[95:0] = {hdr_dw2, hdr_dw1, hdr_dw0};
      end
    end
  end

`ifdef IPS2L_DMA_TX_CPLD_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                         o_cpld_cnt <= '0;
    else if (beat_done && last_beat) o_cpld_cnt <= o_cpld_cnt + 32'd1;
  end
`else
  assign o_cpld_cnt = '0;
`endif

endmodule
